cr_lsu_randclk_ctrl: RTL and testbench

Sequencer for the LSU random-clock (dummy-toggle) enables. It drives the per-group `randclk_*_mod_en` signals that open LSU datapath clock gates on pseudo-random cycles, masking data-dependent power signatures. A 16-bit LFSR provides the random source. A small state machine handles enable, seeding and drain, and per-group run-length counters bound consecutive dummy toggles. It sits beside the LSU gated-clock cells and is configured by SEU control fields.

---
 rtl/cr_lsu_randclk_ctrl.sv | 134 +++++++++++++
 tb/tb_cr_lsu_randclk_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_lsu_randclk_ctrl.sv
// cr_lsu_randclk_ctrl: LFSR-driven dummy-toggle enables for LSU clock gates.
// Ports: forever_cpuclk/cpurst_b (sync, active-low); seu_lsu_randclk_mod_en
//   [31]=global, [NUM_GRP-1:0]=per group; seed_vld/seed load the LFSR;
//   lsu_randclk_upd_req masks groups doing real writes; outputs are the
//   registered per-group enables, the size-buffer alias, and busy.
module cr_lsu_randclk_ctrl #(
    parameter int LFSR_W  = 16,
    parameter int NUM_GRP = 4,
    parameter int MAX_RUN = 7
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst_b,
    input  logic [31:0]        seu_lsu_randclk_mod_en,
    input  logic               seu_lsu_randclk_seed_vld,
    input  logic [LFSR_W-1:0]  seu_lsu_randclk_seed,
    input  logic [NUM_GRP-1:0] lsu_randclk_upd_req,
    output logic [NUM_GRP-1:0] randclk_grp_mod_en,
    output logic               randclk_dp_size_buf_mod_en_w5,
    output logic               randclk_busy
);

    localparam logic [1:0] ST_OFF   = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0]  RUN_MAX  = CNT_W'(MAX_RUN);
    localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(16'hB400);
    localparam logic [LFSR_W-1:0] LFSR_RST = LFSR_W'(16'hACE1);
    localparam logic [LFSR_W-1:0] LFSR_ONE = LFSR_W'(1);

    logic [1:0]                      state_q, state_d;
    logic                            drain_q, drain_d;
    logic [LFSR_W-1:0]               lfsr_q, lfsr_d;
    logic [NUM_GRP-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_GRP-1:0]              en_q, en_d;
    logic                            busy_q, busy_d;

    logic              glb_en;
    logic              seed_vld;
    logic              run_ok;
    logic [LFSR_W-1:0] lfsr_step;
    logic [LFSR_W-1:0] seed_val;

    // Bits of the control word outside the used fields are ignored.
    logic unused_mod_en;
    assign unused_mod_en = ^seu_lsu_randclk_mod_en[30:NUM_GRP];

    assign glb_en    = seu_lsu_randclk_mod_en[31];
    assign seed_vld  = seu_lsu_randclk_seed_vld;
    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    // A zero seed would lock the LFSR at zero forever.
    assign seed_val  = (seu_lsu_randclk_seed == '0) ? LFSR_ONE
                                                    : seu_lsu_randclk_seed;

    // Dummy toggles only while running, enabled, and not in a seed-load cycle.
    assign run_ok = (state_q == ST_RUN) & glb_en & ~seed_vld;

    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        unique case (state_q)
            ST_OFF: begin
                if (glb_en && !seed_vld) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!glb_en) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Two cycles regardless of the enable; drain_q marks the 2nd.
                if (drain_q) begin
                    state_d = ST_OFF;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    always_comb begin
        en_d  = '0;
        cnt_d = '0;
        for (int i = 0; i < NUM_GRP; i++) begin
            // A real update already opens the gate; a full run forces a gap.
            en_d[i] = run_ok
                    & seu_lsu_randclk_mod_en[i]
                    & lfsr_q[i]
                    & ~lsu_randclk_upd_req[i]
                    & (cnt_q[i] != RUN_MAX);
            cnt_d[i] = en_d[i] ? (cnt_q[i] + 1'b1) : '0;
        end
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_vld) begin
            lfsr_d = seed_val;
        end else if (state_q == ST_RUN) begin
            lfsr_d = lfsr_step;
        end
    end

    assign busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q <= ST_OFF;
            drain_q <= 1'b0;
            lfsr_q  <= LFSR_RST;
            cnt_q   <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign randclk_grp_mod_en            = en_q;
    assign randclk_dp_size_buf_mod_en_w5 = en_q[0];
    assign randclk_busy                  = busy_q;

endmodule

// File: tb/tb_cr_lsu_randclk_ctrl.sv
// tb_cr_lsu_randclk_ctrl: bench for the LSU random-clock sequencer.
// Reference model feeds a scoreboard queue; table and hand sequences on top.
module tb_cr_lsu_randclk_ctrl;

    localparam int S_OFF   = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] mod_en;
    logic        sv;
    logic [15:0] seed;
    logic [3:0]  upd;
    logic [3:0]  grp;
    logic        w5;
    logic        busy;

    cr_lsu_randclk_ctrl #(
        .LFSR_W  (16),
        .NUM_GRP (4),
        .MAX_RUN (7)
    ) dut (
        .forever_cpuclk                (clk),
        .cpurst_b                      (rst_n),
        .seu_lsu_randclk_mod_en        (mod_en),
        .seu_lsu_randclk_seed_vld      (sv),
        .seu_lsu_randclk_seed          (seed),
        .lsu_randclk_upd_req           (upd),
        .randclk_grp_mod_en            (grp),
        .randclk_dp_size_buf_mod_en_w5 (w5),
        .randclk_busy                  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  grp;
        logic        busy;
        logic [15:0] lfsr;
        int          state;
    } exp_t;

    typedef struct {
        logic        rst_n;
        logic [31:0] mod_en;
        logic        sv;
        logic [15:0] seed;
        logic [3:0]  upd;
        logic [3:0]  grp;
        logic        busy;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[13];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_state;
    int          m_dleft;
    logic [15:0] m_lfsr;
    int          m_cnt[4];
    int          obs_run[4];

    function automatic logic [15:0] nxt(logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        exp_t e;
        logic [3:0] en;
        int worst;
        en = '0;
        if (!rst_n) begin
            m_state = S_OFF;
            m_dleft = 0;
            m_lfsr  = 16'hACE1;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                en[i] = (m_state == S_RUN) && mod_en[31] && !sv &&
                        mod_en[i] && m_lfsr[i] && !upd[i] && (m_cnt[i] < 7);
                m_cnt[i] = en[i] ? m_cnt[i] + 1 : 0;
            end
            if (sv) m_lfsr = (seed == 16'h0) ? 16'h0001 : seed;
            else if (m_state == S_RUN) m_lfsr = nxt(m_lfsr);
            if (m_state == S_OFF) begin
                if (mod_en[31] && !sv) m_state = S_RUN;
            end else if (m_state == S_RUN) begin
                if (!mod_en[31]) begin
                    m_state = S_DRAIN;
                    m_dleft = 1;
                end
            end else begin
                if (m_dleft == 0) m_state = S_OFF;
                else m_dleft--;
            end
        end
        e.grp   = en;
        e.busy  = (m_state != S_OFF);
        e.lfsr  = m_lfsr;
        e.state = m_state;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("sb_grp", grp, e.grp);
        chk("sb_w5", w5, e.grp[0]);
        chk("sb_busy", busy, e.busy);
        chk("sb_lfsr", dut.lfsr_q, e.lfsr);
        chk("sb_state", dut.state_q, e.state);
        worst = 0;
        for (int i = 0; i < 4; i++) begin
            obs_run[i] = grp[i] ? obs_run[i] + 1 : 0;
            if (obs_run[i] > worst) worst = obs_run[i];
        end
        chk("runlen_le7", worst <= 7, 1);
    endtask

    initial begin
        logic [8:0] pat;
        rst_n  = 1'b0;
        mod_en = 32'hFFFF_FFFF;
        sv     = 1'b0;
        seed   = 16'h0;
        upd    = 4'h0;
        for (int i = 0; i < 4; i++) obs_run[i] = 0;
        m_state = S_OFF;
        m_dleft = 0;
        m_lfsr  = 16'hACE1;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;

        // Reset, enable, then LFSR low nibble from 16'hACE1 one cycle late.
        vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'hFFFF_FFFF, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0};
        vecs[2]  = '{1'b1, 32'h8000_000F, 1'b0, 16'h0, 4'h0, 4'h0, 1'b1};
        vecs[3]  = '{1'b1, 32'h8000_000F, 1'b0, 16'h0, 4'h0, 4'h1, 1'b1};
        vecs[4]  = '{1'b1, 32'h8000_000F, 1'b0, 16'h0, 4'h0, 4'h0, 1'b1};
        vecs[5]  = '{1'b1, 32'h8000_000F, 1'b0, 16'h0, 4'h0, 4'h8, 1'b1};
        vecs[6]  = '{1'b1, 32'h8000_000F, 1'b0, 16'h0, 4'h0, 4'hC, 1'b1};
        vecs[7]  = '{1'b1, 32'h8000_000F, 1'b0, 16'h0, 4'h0, 4'hE, 1'b1};
        vecs[8]  = '{1'b1, 32'h8000_000F, 1'b0, 16'h0, 4'h0, 4'h7, 1'b1};
        vecs[9]  = '{1'b1, 32'h8000_000F, 1'b0, 16'h0, 4'h0, 4'h3, 1'b1};
        vecs[10] = '{1'b1, 32'h8000_000F, 1'b0, 16'h0, 4'h0, 4'h9, 1'b1};
        vecs[11] = '{1'b1, 32'h8000_000F, 1'b0, 16'h0, 4'h4, 4'h0, 1'b1};
        vecs[12] = '{1'b1, 32'h8000_000F, 1'b0, 16'h0, 4'h0, 4'h2, 1'b1};

        for (int k = 0; k < 13; k++) begin
            rst_n  = vecs[k].rst_n;
            mod_en = vecs[k].mod_en;
            sv     = vecs[k].sv;
            seed   = vecs[k].seed;
            upd    = vecs[k].upd;
            tick();
            chk($sformatf("vec%0d_grp", k), grp, vecs[k].grp);
            chk($sformatf("vec%0d_busy", k), busy, vecs[k].busy);
            if (k == 1) chk("rst_lfsr", dut.lfsr_q, 16'hACE1);
        end

        // Zero seed in RUN substitutes 1, then steps to 16'hB400.
        sv = 1'b1; seed = 16'h0000;
        tick();
        chk("seed0_lfsr", dut.lfsr_q, 16'h0001);
        chk("seed0_grp", grp, 4'h0);
        sv = 1'b0;
        tick();
        chk("seed0_step", dut.lfsr_q, 16'hB400);

        // Real updates on group 0 keep the size-buffer enable low.
        upd = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("upd_w5", w5, 1'b0);
            chk("upd_cnt0", dut.cnt_q[0], 3'd0);
        end
        upd = 4'b0000;

        // All-ones seed: group 0 saturates at 7 then takes one gap.
        sv = 1'b1; seed = 16'hFFFF;
        tick();
        chk("ffff_grp", grp, 4'h0);
        sv = 1'b0;
        pat = 9'b1_0111_1111;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("maxrun_%0d", k), w5, pat[k]);
        end

        // Drop global enable for one edge: 2-cycle drain, 1 cycle OFF.
        mod_en = 32'h0000_000F;
        tick();
        chk("drain0_grp", grp, 4'h0);
        chk("drain0_st", dut.state_q, S_DRAIN);
        chk("drain0_busy", busy, 1'b1);
        mod_en = 32'h8000_000F;
        tick();
        chk("drain1_st", dut.state_q, S_DRAIN);
        chk("drain1_busy", busy, 1'b1);
        tick();
        chk("drain2_st", dut.state_q, S_OFF);
        chk("drain2_busy", busy, 1'b0);
        tick();
        chk("reen_st", dut.state_q, S_RUN);
        chk("reen_busy", busy, 1'b1);
        tick();

        // Seed load coinciding with enable fall.
        sv = 1'b1; seed = 16'h1234; mod_en = 32'h0000_000F;
        tick();
        chk("sdfall_lfsr", dut.lfsr_q, 16'h1234);
        chk("sdfall_st", dut.state_q, S_DRAIN);
        chk("sdfall_grp", grp, 4'h0);
        sv = 1'b0; mod_en = 32'h8000_000F;
        for (int k = 0; k < 4; k++) tick();

        // Randomised stretch against the model.
        for (int k = 0; k < 300; k++) begin
            mod_en = {($urandom_range(0, 15) != 0), 27'h0, 4'($urandom)};
            upd    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            sv     = ($urandom_range(0, 31) == 0);
            seed   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            tick();
        end
        sv = 1'b0; upd = 4'h0; mod_en = 32'h8000_000F;
        for (int k = 0; k < 5; k++) tick();

        // Mid-run reset.
        rst_n = 1'b0;
        tick();
        chk("mrst_grp", grp, 4'h0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_st", dut.state_q, S_OFF);
        chk("mrst_lfsr", dut.lfsr_q, 16'hACE1);
        chk("mrst_cnt", dut.cnt_q, 12'h0);
        rst_n = 1'b1;

        // Seed load in OFF blocks entry to RUN for that cycle.
        sv = 1'b1; seed = 16'h5555;
        tick();
        chk("offseed_st", dut.state_q, S_OFF);
        chk("offseed_busy", busy, 1'b0);
        sv = 1'b0;
        tick();
        chk("offseed_run", dut.state_q, S_RUN);
        for (int k = 0; k < 40; k++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
